// File: rtl/pwm_v.sv
// rtl/pwm_v.sv - fixed-frequency left-aligned PWM generator for the audio output path
// Duty is latched only on the period wrap so the pulse width never changes mid-period.
module pwm_v #(
  parameter int WIDTH = 10
) (
  input  logic             Clk_pwm,
  input  logic             Rst_pwm_n,
  input  logic [WIDTH-1:0] SigVec,
  output logic             PwmSig,
  output logic             PrdStart
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             prd_q, prd_d;

  // Outputs are computed from the next-state values so they line up with the
  // registered counter/duty rather than lagging them by a cycle.
  always_comb begin
    cnt_d  = cnt_q + WIDTH'(1);
    duty_d = duty_q;
    if (cnt_q == {WIDTH{1'b1}}) begin
      duty_d = SigVec;
    end
    pwm_d = (cnt_d < duty_d);
    prd_d = (cnt_d == '0);
  end

  always_ff @(posedge Clk_pwm or negedge Rst_pwm_n) begin
    if (!Rst_pwm_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      prd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      prd_q  <= prd_d;
    end
  end

  assign PwmSig   = pwm_q;
  assign PrdStart = prd_q;

endmodule

// File: tb/tb_pwm_v.sv
// tb/tb_pwm_v.sv - self-checking bench for pwm_v
// Samples on the falling edge; each measured period starts at a PrdStart cycle.
module tb_pwm_v;

  localparam int W   = 10;
  localparam int PRD = 1 << W;

  logic         Clk_pwm = 1'b0;
  logic         Rst_pwm_n;
  logic [W-1:0] SigVec;
  logic         PwmSig;
  logic         PrdStart;

  int n_cmp = 0;
  int n_err = 0;

  pwm_v #(.WIDTH(W)) dut (
    .Clk_pwm  (Clk_pwm),
    .Rst_pwm_n(Rst_pwm_n),
    .SigVec   (SigVec),
    .PwmSig   (PwmSig),
    .PrdStart (PrdStart)
  );

  always #5 Clk_pwm = ~Clk_pwm;

  typedef struct {
    string        name;
    logic [W-1:0] sig;
    int           chg_k;
    int           exp_high;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at the negedge of a cnt=0 cycle; leaves at the next one.
  // SigVec is set to sig at offset chg_k; exp_high is the duty already latched.
  task automatic run_period(input string name, input logic [W-1:0] sig,
                            input int chg_k, input int exp_high);
    int highs = 0;
    int pat_err = 0;
    int prd_err = 0;
    for (int k = 0; k < PRD; k++) begin
      if (PwmSig) highs++;
      if (PwmSig !== (k < exp_high)) pat_err++;
      if (PrdStart !== (k == 0)) prd_err++;
      if (k == chg_k) SigVec = sig;
      @(negedge Clk_pwm);
    end
    chk({name, "_high"}, highs, exp_high);
    chk({name, "_shape"}, pat_err, 0);
    chk({name, "_prdstart"}, prd_err, 0);
  endtask

  // Entered at a negedge while reset is held; leaves at the first PrdStart negedge.
  task automatic release_check(input string name);
    int lows = 0;
    int highs = 0;
    int seen = 0;
    Rst_pwm_n = 1'b1;
    for (int k = 0; k < 2 * PRD; k++) begin
      @(negedge Clk_pwm);
      if (PrdStart) begin
        seen = 1;
        break;
      end
      lows++;
      if (PwmSig) highs++;
    end
    chk({name, "_prdstart_seen"}, seen, 1);
    chk({name, "_partial_len"}, lows, PRD - 1);
    chk({name, "_partial_high"}, highs, 0);
  endtask

  initial begin
    int rst_err;

    tbl.push_back('{"sweep0",    10'd0,    0, 512});
    tbl.push_back('{"sweep1",    10'd1,    0, 0});
    tbl.push_back('{"sweep511",  10'd511,  0, 1});
    tbl.push_back('{"sweep512",  10'd512,  0, 511});
    tbl.push_back('{"sweep513",  10'd513,  0, 512});
    tbl.push_back('{"sweep1022", 10'd1022, 0, 513});
    tbl.push_back('{"sweep1023", 10'd1023, 0, 1022});
    tbl.push_back('{"max",       10'd0,    0, 1023});
    tbl.push_back('{"zero_a",    10'd0,    0, 0});
    tbl.push_back('{"zero_b",    10'd512,  0, 0});
    tbl.push_back('{"midchg",    10'd256,  100, 512});
    tbl.push_back('{"lastchg",   10'd768,  PRD - 1, 256});
    tbl.push_back('{"after768",  10'd512,  0, 768});

    Rst_pwm_n = 1'b0;
    SigVec    = 10'd512;
    rst_err   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk_pwm);
      if (PwmSig !== 1'b0 || PrdStart !== 1'b0) rst_err++;
    end
    chk("reset_outputs_low", rst_err, 0);
    chk("reset_pwm", int'(PwmSig), 0);

    release_check("rel1");
    for (int p = 0; p < 3; p++) begin
      run_period($sformatf("mid_p%0d", p), 10'd512, 0, 512);
    end

    foreach (tbl[i]) begin
      run_period(tbl[i].name, tbl[i].sig, tbl[i].chg_k, tbl[i].exp_high);
    end

    // Now at cnt=0 with duty 512: step to cnt=200, then reset between edges.
    for (int k = 0; k < 200; k++) @(negedge Clk_pwm);
    chk("pre_reset_high", int'(PwmSig), 1);
    #2 Rst_pwm_n = 1'b0;
    #1;
    chk("async_reset_pwm", int'(PwmSig), 0);
    chk("async_reset_prd", int'(PrdStart), 0);
    rst_err = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk_pwm);
      if (PwmSig !== 1'b0 || PrdStart !== 1'b0) rst_err++;
    end
    chk("reset_held", rst_err, 0);

    release_check("rel2");
    run_period("post_rel2", 10'd512, 0, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
